// File: rtl/iterative_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Signed operations run on magnitudes; the signs are reapplied in a single fix-up cycle.
module iterative_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH-1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] quo_r, rem_r, dvs_r, result_r;
   logic             is_rem_r, quo_neg_r, rem_neg_r;

   logic             op_signed_s, dvd_neg_s, dvs_neg_s, div_zero_s, ovf_s, accept_s;
   logic [WIDTH-1:0] dvd_mag_s, dvs_mag_s, rem_next_s;
   logic [WIDTH:0]   rem_shift_s, diff_s;
   logic             qbit_s;

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
      logic [WIDTH-1:0] r;
      if (neg) begin
         r = (~v) + ONE;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Operand decode at acceptance: magnitudes, signs and the two short-cut cases.
   always_comb begin
      op_signed_s = ~op[0];
      dvd_neg_s   = op_signed_s & dividend[WIDTH-1];
      dvs_neg_s   = op_signed_s & divisor[WIDTH-1];
      dvd_mag_s   = apply_sign(dividend, dvd_neg_s);
      dvs_mag_s   = apply_sign(divisor, dvs_neg_s);
      div_zero_s  = (divisor == ZERO);
      ovf_s       = op_signed_s & (dividend == MOST_NEG) & (divisor == ALL_ONES);
      accept_s    = start & ~flush & (state_r == IDLE);
   end

   // One restoring step; the shifted partial remainder keeps its full WIDTH+1 bits for the trial.
   always_comb begin
      rem_shift_s = {rem_r, quo_r[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, dvs_r};
      qbit_s      = (rem_shift_s >= {1'b0, dvs_r});
      if (qbit_s) begin
         rem_next_s = WIDTH'(diff_s);
      end else begin
         rem_next_s = WIDTH'(rem_shift_s);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush overrides everything, including a same-cycle start.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_nxt_s = (div_zero_s || ovf_s) ? DONE : CALC;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            CALC: begin
               if (cnt_r == LAST_STEP) begin
                  state_nxt_s = FIX;
               end else begin
                  state_nxt_s = CALC;
               end
            end
            FIX:     state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Datapath: operand capture, iteration, sign fix-up and result hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= {CW{1'b0}};
         quo_r     <= ZERO;
         rem_r     <= ZERO;
         dvs_r     <= ZERO;
         result_r  <= ZERO;
         is_rem_r  <= 1'b0;
         quo_neg_r <= 1'b0;
         rem_neg_r <= 1'b0;
      end else if (flush) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  cnt_r     <= {CW{1'b0}};
                  quo_r     <= dvd_mag_s;
                  rem_r     <= ZERO;
                  dvs_r     <= dvs_mag_s;
                  is_rem_r  <= op[1];
                  quo_neg_r <= dvd_neg_s ^ dvs_neg_s;
                  rem_neg_r <= dvd_neg_s;
                  if (div_zero_s) begin
                     result_r <= op[1] ? dividend : ALL_ONES;
                  end else if (ovf_s) begin
                     result_r <= op[1] ? ZERO : dividend;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_next_s;
               quo_r <= {quo_r[WIDTH-2:0], qbit_s};
               cnt_r <= cnt_r + CW'(1);
            end
            FIX: begin
               result_r <= is_rem_r ? apply_sign(rem_r, rem_neg_r) : apply_sign(quo_r, quo_neg_r);
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Outputs are decoded straight from registered state.
   always_comb begin
      busy   = (state_r != IDLE);
      done   = (state_r == DONE);
      result = result_r;
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_iterative_divider;

   localparam int W = 32;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   typedef struct {
      logic [W-1:0] res;
      int           k;
      int           lat;
      string        name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done;
   logic [W-1:0] result;

   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] last_exp = '0;

   iterative_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
      .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sd, q, r;
      if (b == '0) return o[1] ? a : '1;
      if (o[0]) return o[1] ? (a % b) : (a / b);
      if (a == 32'h8000_0000 && b == '1) return o[1] ? '0 : a;
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      q  = sa / sd;
      r  = sa % sd;
      return o[1] ? r[W-1:0] : q[W-1:0];
   endfunction

   function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == '0) || (!o[0] && a == 32'h8000_0000 && b == '1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for idle, presents one request for exactly one edge, then scrambles the inputs.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] exp, input string name);
      int guard = 0;
      while (busy !== 1'b0 && guard < 200) begin
         tick();
         guard++;
      end
      if (busy !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s wait_idle: busy=%b, expected 0 within 200 cycles", name, busy);
      end
      start    = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      check({name, " busy_at_k"}, 64'(busy), 64'd1);
      if (push) begin
         sb.push_back('{res: exp, k: cyc, lat: (is_special(o, a, b) ? 0 : W + 1), name: name});
         last_exp = exp;
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation in value and latency.
   always @(negedge clk) begin
      if (rst === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 with result %0h, expected no pulse", result);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, " result"}, 64'(result), 64'(mon_e.res));
            check({mon_e.name, " latency"}, 64'(cyc - mon_e.k), 64'(mon_e.lat));
         end
      end
   end

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      int           g;

      repeat (3) tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", 64'(result), 64'd0);
      rst = 1'b1;

      issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, "divu_100_7");
      issue(OP_REMU, 32'd100, 32'd7, 1'b1, 32'd2, "remu_100_7");
      issue(OP_DIV, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, "div_m7_2");
      issue(OP_REM, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, "rem_m7_2");
      issue(OP_DIV, 32'd7, -32'sd2, 1'b1, 32'hFFFF_FFFD, "div_7_m2");
      issue(OP_REM, 32'd7, -32'sd2, 1'b1, 32'd1, "rem_7_m2");
      issue(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, "divu_by_zero");
      issue(OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, "rem_by_zero");
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, "div_overflow");
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, "rem_overflow");

      // Flush at edge k+10 with a start in the same cycle, then restart at edge k+11.
      issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0, "flushed");
      repeat (9) tick();
      flush    = 1'b1;
      start    = 1'b1;
      op       = OP_DIVU;
      dividend = 32'd50;
      divisor  = 32'd0;
      tick();
      flush = 1'b0;
      start = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush result_hold", 64'(result), 64'(last_exp));
      issue(OP_DIVU, 32'd1000, 32'd3, 1'b1, 32'd333, "after_flush");

      // A start raised mid-operation must be ignored.
      issue(OP_DIV, -32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, "div_m100_7");
      repeat (4) tick();
      start    = 1'b1;
      op       = OP_DIVU;
      dividend = 32'd5;
      divisor  = 32'd0;
      tick();
      start = 1'b0;
      check("ignored_start busy", 64'(busy), 64'd1);

      // Asynchronous reset mid-CALC, with a second start pending.
      issue(OP_DIVU, 32'd77, 32'd8, 1'b0, '0, "reset_victim");
      repeat (6) tick();
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 32'd3;
      #2;
      rst = 1'b0;
      #1;
      check("midreset busy", 64'(busy), 64'd0);
      check("midreset done", 64'(done), 64'd0);
      check("midreset result", 64'(result), 64'd0);
      start    = 1'b0;
      rst      = 1'b1;
      last_exp = '0;
      issue(OP_REMU, 32'd77, 32'd8, 1'b1, 32'd5, "after_reset");

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(3, 0));
         case ($urandom_range(3, 0))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(1000, 0);
            default: ra = $urandom;
         endcase
         case ($urandom_range(4, 0))
            0:       rb = '0;
            1:       rb = '1;
            2:       rb = $urandom_range(20, 1);
            3:       rb = -$urandom_range(20, 1);
            default: rb = $urandom;
         endcase
         issue(ro, ra, rb, 1'b1, model(ro, ra, rb), "random");
      end

      g = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && g < 200) begin
         tick();
         g++;
      end
      while (sb.size() != 0) begin
         mon_e = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s missing_done: got no done pulse, expected result %0h", mon_e.name, mon_e.res);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
